// File: rtl/servo_pen_sequencer.sv
// Pen-lift servo sequencer: accepts up/down commands, slews the PWM width, settles, pulses done.
// Optional stepped slew is enabled by defining SERVO_SLEW_EN; otherwise the width jumps in one frame.
module servo_pen_sequencer #(
  parameter int PERIOD        = 2000000,
  parameter int POS_UP        = 150000,
  parameter int POS_DOWN      = 200000,
  parameter int STEP          = 5000,
  parameter int SETTLE_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic        cmd_down,
  output logic        cmd_ready,
  output logic        busy,
  output logic        done,
  output logic        pen_is_down,
  output logic [20:0] cur_width,
  output logic        pwm
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SLEW   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

`ifdef SERVO_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  // Without stepped slew the per-frame limit is lifted, so one frame reaches target.
  localparam logic [20:0] STP   = SLEW_ON ? 21'(STEP) : {21{1'b1}};
  localparam logic [20:0] P_UP  = 21'(POS_UP);
  localparam logic [20:0] P_DN  = 21'(POS_DOWN);
  localparam logic [20:0] F_END = 21'(PERIOD - 1);
  localparam int          SW    = $clog2(SETTLE_FRAMES + 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_FRAMES - 1);

  logic [1:0]    state;
  logic [20:0]   frame_cnt;
  logic [20:0]   target;
  logic [20:0]   nxt_w;
  logic [20:0]   cmd_tgt;
  logic [SW-1:0] settle_cnt;
  logic          frame_end;

  assign frame_end   = (frame_cnt == F_END);
  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign pen_is_down = (state == IDLE) && (cur_width == P_DN);
  assign cmd_tgt     = cmd_down ? P_DN : P_UP;

  // Free-running frame counter, wraps every PERIOD cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 21'd1;
    end
  end

  // Registered PWM output; one cycle behind the frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= (frame_cnt < cur_width);
    end
  end

  // Next width: move toward target by at most STP, compare before subtract.
  always_comb begin
    nxt_w = target;
    if (target > cur_width) begin
      if ((target - cur_width) > STP) begin
        nxt_w = cur_width + STP;
      end
    end else if ((cur_width - target) > STP) begin
      nxt_w = cur_width - STP;
    end
  end

  // Command FSM; width only changes on frame_end so every pulse is whole.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_width  <= P_UP;
      target     <= P_UP;
      settle_cnt <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            target     <= cmd_tgt;
            settle_cnt <= '0;
            state      <= (cmd_tgt != cur_width) ? SLEW : SETTLE;
          end
        end
        SLEW: begin
          if (frame_end) begin
            cur_width <= nxt_w;
            if (nxt_w == target) begin
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (frame_end) begin
            if (settle_cnt == S_LAST) begin
              settle_cnt <= '0;
              state      <= IDLE;
              done       <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pen_sequencer.sv
// Directed bench for servo_pen_sequencer with small frame parameters.
// Expected widths follow SERVO_SLEW_EN when it is defined for the build.
module tb_servo_pen_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_down = 1'b0;
  logic        cmd_ready;
  logic        busy;
  logic        done;
  logic        pen_is_down;
  logic [20:0] cur_width;
  logic        pwm;

  servo_pen_sequencer #(
    .PERIOD(100),
    .POS_UP(10),
    .POS_DOWN(25),
    .STEP(4),
    .SETTLE_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_down(cmd_down),
    .cmd_ready(cmd_ready),
    .busy(busy),
    .done(done),
    .pen_is_down(pen_is_down),
    .cur_width(cur_width),
    .pwm(pwm)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nbad = 0;
  int fc = 0;
  bit tog = 1'b0;
  bit mon_en = 1'b0;
  int run = 0;
  int runs = 0;
  int badlen = 0;
  int dn[$];
  int up[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    fc = (fc + 1) % 100;
    @(negedge clk);
    if (tog) cmd_down = ~cmd_down;
  endtask

  task automatic goto_fc(input int t);
    do step(); while (fc != t);
  endtask

  task automatic count_frame(output int n);
    n = 0;
    repeat (100) begin
      if (pwm === 1'b1) n++;
      step();
    end
  endtask

  // Pulse-length monitor: every completed high run must be a legal width.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pwm === 1'b1) begin
        run++;
      end else if (run != 0) begin
        if (!(run inside {10, 14, 18, 22, 25})) badlen++;
        runs++;
        run = 0;
      end
    end
  end

  initial begin
    int n;
    int k;
`ifdef SERVO_SLEW_EN
    dn = '{14, 18, 22, 25};
    up = '{21, 17, 13, 10};
`else
    dn = '{25};
    up = '{10};
`endif
    k = (dn.size() > 1) ? 1 : 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_width", 32'(cur_width), 10);
    chk("rst_pwm", 32'(pwm), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pen", 32'(pen_is_down), 0);
    rst = 1'b0;
    fc = 0;

    // 1: idle PWM, 10 high per 100
    count_frame(n);
    chk("t1_frame0", n, 10);
    count_frame(n);
    chk("t1_frame1", n, 10);
    chk("t1_width", 32'(cur_width), 10);
    chk("t1_ready", 32'(cmd_ready), 1);
    chk("t1_done", 32'(done), 0);

    // 2: pen down mid-frame
    goto_fc(50);
    cmd_valid = 1'b1;
    cmd_down = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("t2_busy", 32'(busy), 1);
    chk("t2_ready", 32'(cmd_ready), 0);
    foreach (dn[i]) begin
      goto_fc(0);
      chk($sformatf("t2_w%0d", i), 32'(cur_width), 32'(dn[i]));
    end
    count_frame(n);
    chk("t2_pulse25", n, 25);
    chk("t2_settle_busy", 32'(busy), 1);
    chk("t2_settle_done", 32'(done), 0);
    goto_fc(0);
    chk("t2_done", 32'(done), 1);
    chk("t2_busy_low", 32'(busy), 0);
    chk("t2_pen", 32'(pen_is_down), 1);
    chk("t2_ready1", 32'(cmd_ready), 1);
    step();
    chk("t2_done_1cyc", 32'(done), 0);

    // 3: pen up from 25
    goto_fc(20);
    cmd_valid = 1'b1;
    cmd_down = 1'b0;
    step();
    cmd_valid = 1'b0;
    foreach (up[i]) begin
      goto_fc(0);
      chk($sformatf("t3_w%0d", i), 32'(cur_width), 32'(up[i]));
    end
    goto_fc(0);
    chk("t3_nodone", 32'(done), 0);
    goto_fc(0);
    chk("t3_done", 32'(done), 1);
    chk("t3_pen", 32'(pen_is_down), 0);

    // 4: up while already up, settle only
    goto_fc(30);
    cmd_valid = 1'b1;
    cmd_down = 1'b0;
    step();
    cmd_valid = 1'b0;
    chk("t4_busy", 32'(busy), 1);
    goto_fc(0);
    chk("t4_w", 32'(cur_width), 10);
    chk("t4_nodone", 32'(done), 0);
    goto_fc(0);
    chk("t4_done", 32'(done), 1);
    chk("t4_w_end", 32'(cur_width), 10);

    // 5: cmd_valid held while busy, payload toggling
    goto_fc(50);
    run = 0;
    mon_en = 1'b1;
    goto_fc(60);
    cmd_valid = 1'b1;
    cmd_down = 1'b1;
    step();
    tog = 1'b1;
    foreach (dn[i]) begin
      goto_fc(0);
      chk($sformatf("t5_w%0d", i), 32'(cur_width), 32'(dn[i]));
    end
    goto_fc(0);
    goto_fc(0);
    mon_en = 1'b0;
    tog = 1'b0;
    chk("t5_done", 32'(done), 1);
    chk("t5_ready", 32'(cmd_ready), 1);
    chk("t5_badlen", badlen, 0);
    chk("t5_runs", 32'(runs >= 2), 1);
    cmd_down = 1'b0;
    step();
    cmd_valid = 1'b0;
    chk("t5_reaccept", 32'(busy), 1);
    chk("t5_done_low", 32'(done), 0);
    foreach (up[i]) begin
      goto_fc(0);
      chk($sformatf("t5_up%0d", i), 32'(cur_width), 32'(up[i]));
    end
    goto_fc(0);
    goto_fc(0);
    chk("t5_done2", 32'(done), 1);

    // Accept on the frame_end cycle: latch only
    goto_fc(99);
    cmd_valid = 1'b1;
    cmd_down = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("fe_latch_w", 32'(cur_width), 10);
    chk("fe_busy", 32'(busy), 1);
    for (int i = 0; i <= k; i++) begin
      goto_fc(0);
      chk($sformatf("fe_w%0d", i), 32'(cur_width), 32'(dn[i]));
    end

    // 6: async reset mid-command
    goto_fc(5);
    chk("t6_pwm_pre", 32'(pwm), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_width", 32'(cur_width), 10);
    chk("t6_pwm", 32'(pwm), 0);
    chk("t6_idle", 32'(cmd_ready), 1);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    chk("t6_done_hold", 32'(done), 0);
    rst = 1'b0;
    fc = 0;
    count_frame(n);
    chk("t6_frame", n, 10);
    chk("t6_done_after", 32'(done), 0);
    chk("t6_width_after", 32'(cur_width), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
